// File: rtl/sb_pkg.sv
// rtl/sb_pkg.sv - shared types and helpers for the stream scoreboard
package sb_pkg;

  typedef enum logic [1:0] {SB_IDLE, SB_FRAME, SB_HALT} sb_state_t;

  localparam int SB_DATA_W_DEF = 8;
  localparam int SB_CNT_W_DEF  = 16;
  // Every counter saturates at its all-ones value; this is the fill bit.
  localparam logic SB_CNT_SAT_BIT = 1'b1;

  typedef struct packed {
    logic                     last;
    logic [SB_DATA_W_DEF-1:0] data;
  } sb_beat_t;

  function automatic int sb_beat_w(input int data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// rtl/sb_fifo.sv - first-word-fall-through FIFO holding expected beats
module sb_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the addresses match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/stream_scoreboard.sv
// rtl/stream_scoreboard.sv - in-line checker comparing an actual stream against buffered expected beats
module stream_scoreboard
  import sb_pkg::*;
#(
  parameter int DATA_W      = SB_DATA_W_DEF,
  parameter int DEPTH       = 16,
  parameter int CNT_W       = SB_CNT_W_DEF,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              clr,
  input  logic              expValid,
  input  logic [DATA_W-1:0] expData,
  input  logic              expLast,
  output logic              expReady,
  input  logic              actValid,
  input  logic [DATA_W-1:0] actData,
  input  logic              actLast,
  output logic              matchPulse,
  output logic              errPulse,
  output logic              underflow,
  output logic              frameDone,
  output logic              frameOk,
  output logic              stickyErr,
  output logic [CNT_W-1:0]  beatCnt,
  output logic [CNT_W-1:0]  errCnt,
  output logic [CNT_W-1:0]  frameCnt,
  output logic              halted
);

  localparam int              BW      = sb_beat_w(DATA_W);
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{SB_CNT_SAT_BIT}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + CNT_ONE;
  endfunction

  sb_state_t        state_q, state_d;
  logic             rdy_q;
  logic             frame_err_q, frame_err_d;
  logic             match_q, match_d, err_q, err_d, uf_q, uf_d;
  logic             fd_q, fd_d, fok_q, fok_d, sticky_q, sticky_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d, err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic [BW-1:0]    fifo_beat;
  logic             fifo_full, fifo_empty;
  logic             act_take, beat_err;

  // rdy_q holds expReady low until the first edge after reset release.
  assign expReady = rdy_q && !fifo_full && (state_q != SB_HALT);
  assign act_take = actValid && (state_q != SB_HALT) && !clr;
  assign beat_err = act_take && (fifo_empty || (fifo_beat != {actLast, actData}));

  sb_fifo #(
    .WIDTH (BW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstN    (rstN),
    .flush_i (clr),
    .push_i  (expValid && expReady),
    .wdata_i ({expLast, expData}),
    .pop_i   (act_take),
    .rdata_o (fifo_beat),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    frame_err_d = frame_err_q;
    sticky_d    = sticky_q;
    beat_cnt_d  = beat_cnt_q;
    err_cnt_d   = err_cnt_q;
    frame_cnt_d = frame_cnt_q;
    match_d     = 1'b0;
    err_d       = 1'b0;
    uf_d        = 1'b0;
    fd_d        = 1'b0;
    fok_d       = 1'b0;
    if (clr) begin
      state_d     = SB_IDLE;
      frame_err_d = 1'b0;
      sticky_d    = 1'b0;
      beat_cnt_d  = '0;
      err_cnt_d   = '0;
      frame_cnt_d = '0;
    end else if (act_take) begin
      match_d = !beat_err;
      err_d   = beat_err;
      uf_d    = fifo_empty;
      if (!fifo_empty) beat_cnt_d = sat_inc(beat_cnt_q);
      if (beat_err) begin
        err_cnt_d = sat_inc(err_cnt_q);
        sticky_d  = 1'b1;
      end
      if (actLast) begin
        fd_d        = 1'b1;
        fok_d       = !(frame_err_q || beat_err);
        frame_cnt_d = sat_inc(frame_cnt_q);
        frame_err_d = 1'b0;
        state_d     = SB_IDLE;
      end else begin
        frame_err_d = frame_err_q || beat_err;
        state_d     = SB_FRAME;
      end
      if (STOP_ON_ERR && beat_err) state_d = SB_HALT;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= SB_IDLE;
      rdy_q       <= 1'b0;
      frame_err_q <= 1'b0;
      match_q     <= 1'b0;
      err_q       <= 1'b0;
      uf_q        <= 1'b0;
      fd_q        <= 1'b0;
      fok_q       <= 1'b0;
      sticky_q    <= 1'b0;
      beat_cnt_q  <= '0;
      err_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= 1'b1;
      frame_err_q <= frame_err_d;
      match_q     <= match_d;
      err_q       <= err_d;
      uf_q        <= uf_d;
      fd_q        <= fd_d;
      fok_q       <= fok_d;
      sticky_q    <= sticky_d;
      beat_cnt_q  <= beat_cnt_d;
      err_cnt_q   <= err_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign matchPulse = match_q;
  assign errPulse   = err_q;
  assign underflow  = uf_q;
  assign frameDone  = fd_q;
  assign frameOk    = fok_q;
  assign stickyErr  = sticky_q;
  assign beatCnt    = beat_cnt_q;
  assign errCnt     = err_cnt_q;
  assign frameCnt   = frame_cnt_q;
  assign halted     = (state_q == SB_HALT);

endmodule

// File: tb/tb_stream_scoreboard.sv
// tb/tb_stream_scoreboard.sv - randomized and directed checks of stream_scoreboard against a queue model
module tb_stream_scoreboard;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstN, clr, expValid, expLast, actValid, actLast;
  logic [7:0] expData, actData;

  logic        r0, m0, e0, u0, fd0, fo0, s0, h0;
  logic [3:0]  bc0, ec0, fc0;
  logic        r1, m1, e1, u1, fd1, fo1, s1, h1;
  logic [15:0] bc1, ec1, fc1;

  // Instance 0: narrow counters, keeps running on errors. Instance 1: halts on error.
  stream_scoreboard #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(4), .STOP_ON_ERR(1'b0)) dut0 (
    .clk(clk), .rstN(rstN), .clr(clr),
    .expValid(expValid), .expData(expData), .expLast(expLast), .expReady(r0),
    .actValid(actValid), .actData(actData), .actLast(actLast),
    .matchPulse(m0), .errPulse(e0), .underflow(u0), .frameDone(fd0), .frameOk(fo0),
    .stickyErr(s0), .beatCnt(bc0), .errCnt(ec0), .frameCnt(fc0), .halted(h0));

  stream_scoreboard #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(16), .STOP_ON_ERR(1'b1)) dut1 (
    .clk(clk), .rstN(rstN), .clr(clr),
    .expValid(expValid), .expData(expData), .expLast(expLast), .expReady(r1),
    .actValid(actValid), .actData(actData), .actLast(actLast),
    .matchPulse(m1), .errPulse(e1), .underflow(u1), .frameDone(fd1), .frameOk(fo1),
    .stickyErr(s1), .beatCnt(bc1), .errCnt(ec1), .frameCnt(fc1), .halted(h1));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one queue of expected beats plus plain counters per instance.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  int  m_beat[2], m_err[2], m_frame[2];
  bit  m_sticky[2], m_halt[2], m_ferr[2], m_live[2];
  bit  x_match[2], x_err[2], x_uf[2], x_fd[2], x_fok[2];
  int  cmax[2] = '{15, 65535};
  bit  stop[2] = '{1'b0, 1'b1};

  function automatic int q_size(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  task automatic q_pop(input int k, output logic [8:0] v);
    if (k == 0) v = q0.pop_front();
    else        v = q1.pop_front();
  endtask

  task automatic q_push(input int k, input logic [8:0] v);
    if (k == 0) q0.push_back(v);
    else        q1.push_back(v);
  endtask

  task automatic q_clear(input int k);
    if (k == 0) q0.delete();
    else        q1.delete();
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      q_clear(k);
      m_beat[k] = 0; m_err[k] = 0; m_frame[k] = 0;
      m_sticky[k] = 0; m_halt[k] = 0; m_ferr[k] = 0; m_live[k] = 0;
      x_match[k] = 0; x_err[k] = 0; x_uf[k] = 0; x_fd[k] = 0; x_fok[k] = 0;
    end
  endtask

  function automatic bit model_ready(input int k);
    return m_live[k] && (q_size(k) < DEPTH) && !m_halt[k];
  endfunction

  task automatic model_edge(input int k, input bit c, input bit ev, input logic [7:0] ed,
                            input bit el, input bit av, input logic [7:0] ad, input bit al,
                            input bit rdy);
    logic [8:0] front;
    bit bad;
    x_match[k] = 0; x_err[k] = 0; x_uf[k] = 0; x_fd[k] = 0; x_fok[k] = 0;
    if (c) begin
      q_clear(k);
      m_beat[k] = 0; m_err[k] = 0; m_frame[k] = 0;
      m_sticky[k] = 0; m_ferr[k] = 0; m_halt[k] = 0;
    end else if (!m_halt[k]) begin
      if (av) begin
        bad = 0;
        if (q_size(k) == 0) begin
          bad = 1;
          x_uf[k] = 1;
        end else begin
          q_pop(k, front);
          bad = (front != {al, ad});
          if (m_beat[k] < cmax[k]) m_beat[k]++;
        end
        x_err[k] = bad;
        x_match[k] = !bad;
        if (bad) begin
          if (m_err[k] < cmax[k]) m_err[k]++;
          m_sticky[k] = 1;
        end
        if (al) begin
          x_fd[k] = 1;
          x_fok[k] = !(m_ferr[k] || bad);
          if (m_frame[k] < cmax[k]) m_frame[k]++;
          m_ferr[k] = 0;
        end else begin
          m_ferr[k] = m_ferr[k] || bad;
        end
        if (bad && stop[k]) m_halt[k] = 1;
      end
      if (ev && rdy) q_push(k, {el, ed});
    end
    m_live[k] = 1;
  endtask

  task automatic compare_dut(input int k, input logic [31:0] m, input logic [31:0] e,
                             input logic [31:0] u, input logic [31:0] fd, input logic [31:0] fo,
                             input logic [31:0] s, input logic [31:0] h, input logic [31:0] bc,
                             input logic [31:0] ec, input logic [31:0] fc);
    check_eq($sformatf("d%0d.matchPulse", k), m, 32'(x_match[k]));
    check_eq($sformatf("d%0d.errPulse", k), e, 32'(x_err[k]));
    check_eq($sformatf("d%0d.underflow", k), u, 32'(x_uf[k]));
    check_eq($sformatf("d%0d.frameDone", k), fd, 32'(x_fd[k]));
    check_eq($sformatf("d%0d.frameOk", k), fo, 32'(x_fok[k]));
    check_eq($sformatf("d%0d.stickyErr", k), s, 32'(m_sticky[k]));
    check_eq($sformatf("d%0d.halted", k), h, 32'(m_halt[k]));
    check_eq($sformatf("d%0d.beatCnt", k), bc, 32'(m_beat[k]));
    check_eq($sformatf("d%0d.errCnt", k), ec, 32'(m_err[k]));
    check_eq($sformatf("d%0d.frameCnt", k), fc, 32'(m_frame[k]));
  endtask

  task automatic compare_all();
    compare_dut(0, 32'(m0), 32'(e0), 32'(u0), 32'(fd0), 32'(fo0), 32'(s0), 32'(h0),
                32'(bc0), 32'(ec0), 32'(fc0));
    compare_dut(1, 32'(m1), 32'(e1), 32'(u1), 32'(fd1), 32'(fo1), 32'(s1), 32'(h1),
                32'(bc1), 32'(ec1), 32'(fc1));
  endtask

  task automatic step(input bit c, input bit ev, input logic [7:0] ed, input bit el,
                      input bit av, input logic [7:0] ad, input bit al);
    bit rd0, rd1;
    clr = c; expValid = ev; expData = ed; expLast = el;
    actValid = av; actData = ad; actLast = al;
    #1;
    rd0 = model_ready(0);
    rd1 = model_ready(1);
    if (m_live[0]) check_eq("d0.expReady", 32'(r0), 32'(rd0));
    if (m_live[1]) check_eq("d1.expReady", 32'(r1), 32'(rd1));
    @(posedge clk);
    model_edge(0, c, ev, ed, el, av, ad, al, rd0);
    model_edge(1, c, ev, ed, el, av, ad, al, rd1);
    #1;
    compare_all();
  endtask

  task automatic idle();                                step(0, 0, 8'h00, 0, 0, 8'h00, 0); endtask
  task automatic do_clr();                              step(1, 0, 8'h00, 0, 0, 8'h00, 0); endtask
  task automatic push(input logic [7:0] d, input bit l); step(0, 1, d, l, 0, 8'h00, 0);     endtask
  task automatic act(input logic [7:0] d, input bit l);  step(0, 0, 8'h00, 0, 1, d, l);     endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int mcnt;
    int guard;
    logic [8:0] hold_beat;
    logic [8:0] fr;
    bit c, ev, el, av, al;
    logic [7:0] ed, ad;

    rstN = 0; clr = 0; expValid = 0; expData = 0; expLast = 0;
    actValid = 0; actData = 0; actLast = 0;
    model_reset();
    #12;
    compare_all();
    rstN = 1;
    idle();
    check_eq("reset.expReady_after_edge", 32'(r0), 1);

    // Four-beat frame matched back to back.
    push(8'hAA, 0); push(8'hBB, 0); push(8'hCC, 0); push(8'hDD, 1);
    mcnt = 0;
    act(8'hAA, 0); mcnt += int'(m0);
    act(8'hBB, 0); mcnt += int'(m0);
    act(8'hCC, 0); mcnt += int'(m0);
    act(8'hDD, 1); mcnt += int'(m0);
    check_eq("s1.matches", 32'(mcnt), 4);
    check_eq("s1.frameDone", 32'(fd0), 1);
    check_eq("s1.frameOk", 32'(fo0), 1);
    check_eq("s1.beatCnt", 32'(bc0), 4);
    check_eq("s1.errCnt", 32'(ec0), 0);
    check_eq("s1.frameCnt", 32'(fc0), 1);
    do_clr();

    // Data mismatch on the last beat.
    push(8'h11, 0); push(8'h22, 1);
    act(8'h11, 0); act(8'h23, 1);
    check_eq("s2.errPulse", 32'(e0), 1);
    check_eq("s2.frameOk", 32'(fo0), 0);
    check_eq("s2.stickyErr", 32'(s0), 1);
    check_eq("s2.errCnt", 32'(ec0), 1);
    check_eq("s2.halt_dut1", 32'(h1), 1);
    do_clr();

    // Underflow, then a clean single-beat frame.
    act(8'h55, 1);
    check_eq("s3.underflow", 32'(u0), 1);
    check_eq("s3.errPulse", 32'(e0), 1);
    check_eq("s3.beatCnt", 32'(bc0), 0);
    check_eq("s3.errCnt", 32'(ec0), 1);
    push(8'h55, 1);
    act(8'h55, 1);
    check_eq("s3.match", 32'(m0), 1);
    check_eq("s3.frameOk", 32'(fo0), 1);
    do_clr();

    // Fill to full, pop once while a push is held, then drain 17 beats in order.
    for (int i = 0; i < DEPTH; i++) push(8'($urandom), ($urandom_range(0, 3) == 0));
    check_eq("s4.full_expReady", 32'(r0), 0);
    hold_beat = 9'($urandom);
    fr = q0[0];
    step(0, 1, hold_beat[7:0], hold_beat[8], 1, fr[7:0], fr[8]);
    mcnt = int'(m0);
    check_eq("s4.expReady_after_pop", 32'(r0), 1);
    step(0, 1, hold_beat[7:0], hold_beat[8], 0, 8'h00, 0);
    guard = 0;
    while (q0.size() > 0 && guard < 40) begin
      fr = q0[0];
      act(fr[7:0], fr[8]);
      mcnt += int'(m0);
      guard++;
    end
    check_eq("s4.matches", 32'(mcnt), 17);
    do_clr();

    // Halt on the second beat of a five-beat frame.
    for (int i = 1; i <= 5; i++) push(8'(i), (i == 5));
    act(8'h01, 0);
    act(8'h99, 0);
    check_eq("s5.halted", 32'(h1), 1);
    check_eq("s5.errPulse", 32'(e1), 1);
    for (int i = 3; i <= 5; i++) begin
      act(8'(i), (i == 5));
      check_eq("s5.no_pulse", 32'(e1 | m1 | fd1), 0);
      check_eq("s5.beatCnt_frozen", 32'(bc1), 2);
      check_eq("s5.errCnt_frozen", 32'(ec1), 1);
    end
    do_clr();
    check_eq("s5.clr_halted", 32'(h1), 0);
    check_eq("s5.clr_beatCnt", 32'(bc1), 0);
    check_eq("s5.clr_errCnt", 32'(ec1), 0);
    check_eq("s5.clr_expReady", 32'(r1), 1);
    act(8'h42, 0);
    check_eq("s5.clr_fifo_empty", 32'(u1), 1);
    do_clr();

    // Saturating error counter, then async reset mid-frame.
    for (int i = 0; i < 16; i++) act(8'($urandom), 0);
    check_eq("s6.errCnt_sat", 32'(ec0), 15);
    push(8'h01, 0); push(8'h02, 1);
    act(8'h01, 0);
    #2;
    rstN = 0;
    #1;
    check_eq("s6.rst_pulses", 32'({m0, e0, u0, fd0, fo0, s0, h0}), 0);
    check_eq("s6.rst_beatCnt", 32'(bc0), 0);
    check_eq("s6.rst_errCnt", 32'(ec0), 0);
    check_eq("s6.rst_frameCnt", 32'(fc0), 0);
    check_eq("s6.rst_expReady", 32'(r0), 0);
    model_reset();
    #2;
    rstN = 1;
    idle();

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      c  = ($urandom_range(0, 49) == 0);
      ev = $urandom_range(0, 1) == 1;
      ed = 8'($urandom);
      el = ($urandom_range(0, 3) == 0);
      av = ($urandom_range(0, 2) != 0);
      if (q0.size() > 0 && $urandom_range(0, 15) != 0) begin
        fr = q0[0];
        ad = fr[7:0];
        al = fr[8];
      end else begin
        ad = 8'($urandom);
        al = ($urandom_range(0, 3) == 0);
      end
      step(c, ev, ed, el, av, ad, al);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_scoreboard.md
Name: stream_scoreboard

Overview:
- Synthesizable, parametrised in-line checker for byte/word streams: the eth_udp parser output, the RGMII receiver output, or any valid/data/last stream.
- Buffers an expected-data stream in an internal FIFO and compares every beat of the actual stream against it, including the last flag.
- Keeps saturating match/error/frame counters and per-frame pass/fail, so checking can run on hardware (ILA-visible) and in simulation alike.

Parameters:
DATA_W, 8, width of expData/actData
DEPTH, 16, expected-FIFO depth in beats (power of two, >=2)
CNT_W, 16, width of every statistics counter
STOP_ON_ERR, 0, 1 = enter HALT on first error until clr

Ports:
clk  in  1  single clock for the whole block
rstN  in  1  asynchronous, active-low reset
clr  in  1  sync pulse: zero counters/sticky, flush FIFO, leave HALT
expValid  in  1  expected beat valid
expData  in  DATA_W  expected beat data
expLast  in  1  expected beat is frame end
expReady  out  1  FIFO can accept (= !full && state!=HALT)
actValid  in  1  actual beat valid (no backpressure on actual stream)
actData  in  DATA_W  actual beat data
actLast  in  1  actual beat is frame end
matchPulse  out  1  beat compared equal (data and last)
errPulse  out  1  beat mismatched or underflowed
underflow  out  1  errPulse cause: FIFO empty when actValid
frameDone  out  1  pulse on actual last beat
frameOk  out  1  valid with frameDone: no error in that frame
stickyErr  out  1  set on any error, cleared by clr
beatCnt  out  CNT_W  compared beats
errCnt  out  CNT_W  error beats
frameCnt  out  CNT_W  completed actual frames
halted  out  1  state==HALT

Behaviour:
- Reset (rstN low, async): FIFO empty, state IDLE, all pulses/counters/stickyErr/frameOk/halted = 0. expReady = 1 from the first clk edge after rstN deasserts.
- FIFO push: expValid && expReady. Pop: actValid && !empty && state!=HALT.
- Full and popping in the same cycle: expReady stays 0; no write-through.
- Empty: a same-cycle push does not bypass; actValid sees empty and the beat is an underflow. The pushed beat is stored.
- Comparison: beat ok iff actData==fifoData && actLast==fifoLast. A last-flag mismatch alone is an error.
- Latency: matchPulse/errPulse/underflow/frameDone/frameOk/counters are all registered and appear exactly 1 cycle after the actValid beat. Pulses are 1 cycle wide.
- Underflow beat: errPulse=1, underflow=1, no pop, errCnt increments, beatCnt does not.
- Counters saturate at all-ones (no wrap).
- beatCnt increments on every popped beat. errCnt increments on every error beat. frameCnt increments on actLast in IDLE/FRAME.
- FSM:
  - IDLE: no beat of the current frame seen yet. actValid && !actLast -> FRAME. actValid && actLast -> single-beat frame, frameDone, stay IDLE.
  - FRAME: frameErr register ORs the errors. actValid && actLast -> frameDone, frameOk = !(frameErr | thisBeatErr), frameErr cleared, -> IDLE.
  - HALT (only when STOP_ON_ERR=1): entered in the cycle after any error. In HALT: actual beats are ignored (no pulses, no counting), expReady=0, FIFO contents are held. Exit only via clr.
- clr: highest priority over the same-cycle push/compare, which are discarded. Zeroes counters, stickyErr, frameErr, and the FIFO pointers; state -> IDLE. Outputs take cleared values 1 cycle later.
- Reset asserted mid-frame: everything returns to reset values immediately. No partial frame result is emitted.

Decomposition:
- Package sb_pkg:
  - typedef enum logic [1:0] {SB_IDLE, SB_FRAME, SB_HALT} sb_state_t
  - typedef struct packed {logic last; logic [DATA_W-1:0] data} used via a parametrised width function
  - localparam for the counter saturation value
- Sub-module sb_fifo: synchronous FIFO, DEPTH x (DATA_W+1).
  - Pointers one bit wider than address for full/empty.
  - Async active-low reset on pointers; flush input.
  - Registered read data not required: first-word-fall-through output.

Test Plan:
- Push 4 beats 0xAA,0xBB,0xCC,0xDD(last); drive the same actual stream back-to-back -> 4 matchPulse; frameDone+frameOk=1 on the 4th result cycle; beatCnt=4, errCnt=0, frameCnt=1.
- Expected 0x11,0x22(last), actual 0x11,0x23(last) -> errPulse on the 2nd beat; frameOk=0; stickyErr=1; errCnt=1.
- actValid with empty FIFO (data 0x55) -> underflow=1, errPulse=1, beatCnt=0, errCnt=1. Then push 0x55(last) and resend -> match, frameOk=1 (new frame).
- Fill 16 beats with no actual traffic -> expReady=0 after the 16th push. Then pop 1 with expValid held -> expReady=1 the next cycle; no beat lost; all 17 beats later match in order.
- STOP_ON_ERR=1: mismatch on beat 2 of 5 -> halted=1; beats 3-5 produce no pulses and counters freeze; clr -> halted=0, counters 0, FIFO empty, expReady=1.
- Preload errCnt to all-ones via forced errors (CNT_W=4: 16 errors) -> errCnt stays 0xF. Assert rstN low mid-frame -> all outputs 0 asynchronously.
